// File: rtl/sparse_mac_pkg.sv
// Shared widths, bus types and comparator states for the sparse MAC datapath.
package sparse_mac_pkg;

    localparam int VALUE_W = 16;
    localparam int INDEX_W = 16;

    typedef logic [VALUE_W-1:0] value_bus_t;
    typedef logic [INDEX_W-1:0] index_bus_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        WAIT,
        DONE
    } cmp_state_t;

endpackage

// File: rtl/sparse_head_reg.sv
// One-entry holding register for a decoder token (index, value, terminator flag).
module sparse_head_reg
    import sparse_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic       i_pop,
    input  logic       i_valid,
    input  logic       i_last,
    input  index_bus_t i_index,
    input  value_bus_t i_value,
    output logic       o_ready,
    output logic       o_head_valid,
    output logic       o_head_last,
    output index_bus_t o_head_index,
    output value_bus_t o_head_value
);

    logic       r_valid;
    logic       r_last;
    index_bus_t r_index;
    value_bus_t r_value;
    logic       w_load;

    // A popped head can be refilled in the same cycle, giving full streaming rate.
    assign o_ready = i_enable & (~r_valid | i_pop);
    assign w_load  = i_valid & o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_index <= '0;
            r_value <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_index <= i_index;
            r_value <= i_value;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_head_valid = r_valid;
    assign o_head_last  = r_last;
    assign o_head_index = r_index;
    assign o_head_value = r_value;

endmodule

// File: rtl/sparse_index_comparator.sv
// Intersects two index-sorted sparse streams and emits matched value pairs to the MAC.
// Optional index-order checking with order_err_o is built when SPARSE_CMP_CHECK_EN is defined.
module sparse_index_comparator
    import sparse_mac_pkg::*;
#(
    parameter int NUM_DECODERS = 2,
    parameter int DONE_LATENCY = 2
) (
    input  logic                           mac_clk,
    input  logic                           mac_rst,
    input  logic                           start_i,
    input  logic       [NUM_DECODERS-1:0]  dec_valid_i,
    output logic       [NUM_DECODERS-1:0]  dec_ready_o,
    input  logic       [NUM_DECODERS-1:0]  dec_last_i,
    input  index_bus_t [NUM_DECODERS-1:0]  dec_index_i,
    input  value_bus_t [NUM_DECODERS-1:0]  dec_value_i,
    output logic                           comparator_valid_o,
    output value_bus_t [NUM_DECODERS-1:0]  comparator_data_o,
    output logic                           comparator_done_o
`ifdef SPARSE_CMP_CHECK_EN
    ,
    output logic       [NUM_DECODERS-1:0]  order_err_o
`endif
);

    localparam int CNT_W = $clog2(DONE_LATENCY + 1) + 1;

    if (NUM_DECODERS != 2) begin : g_bad_cfg
        $error("sparse_index_comparator supports exactly two decoder streams");
    end

    cmp_state_t                     r_state;
    logic       [CNT_W-1:0]         r_waitCnt;
    logic       [NUM_DECODERS-1:0]  w_hv;
    logic       [NUM_DECODERS-1:0]  w_hl;
    logic       [NUM_DECODERS-1:0]  w_pop;
    logic       [NUM_DECODERS-1:0]  w_bad;
    logic       [NUM_DECODERS-1:0]  w_data;
    logic       [NUM_DECODERS-1:0]  w_good;
    logic       [NUM_DECODERS-1:0]  w_term;
    index_bus_t [NUM_DECODERS-1:0]  w_idx;
    value_bus_t [NUM_DECODERS-1:0]  w_val;
    logic                           w_enable;
    logic                           w_clear;
    logic                           w_match;

    assign w_enable = (r_state == RUN) || (r_state == FLUSH);
    assign w_clear  = start_i && ((r_state == IDLE) || (r_state == DONE));

    for (genvar k = 0; k < NUM_DECODERS; k++) begin : g_head
        sparse_head_reg u_head (
            .clk          (mac_clk),
            .rst_n        (mac_rst),
            .i_enable     (w_enable),
            .i_clear      (w_clear),
            .i_pop        (w_pop[k]),
            .i_valid      (dec_valid_i[k]),
            .i_last       (dec_last_i[k]),
            .i_index      (dec_index_i[k]),
            .i_value      (dec_value_i[k]),
            .o_ready      (dec_ready_o[k]),
            .o_head_valid (w_hv[k]),
            .o_head_last  (w_hl[k]),
            .o_head_index (w_idx[k]),
            .o_head_value (w_val[k])
        );
    end

    assign w_data = w_hv & ~w_hl;
    assign w_term = w_hv & w_hl;
    assign w_good = w_data & ~w_bad;

`ifdef SPARSE_CMP_CHECK_EN
    index_bus_t [NUM_DECODERS-1:0] r_lastIdx;
    logic       [NUM_DECODERS-1:0] r_seen;
    logic       [NUM_DECODERS-1:0] r_orderErr;

    always_comb begin
        w_bad = '0;
        for (int k = 0; k < NUM_DECODERS; k++) begin
            w_bad[k] = w_data[k] & r_seen[k] & (w_idx[k] <= r_lastIdx[k]);
        end
    end

    // Out-of-order heads are dropped and flagged; only accepted indices advance the reference.
    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_lastIdx  <= '0;
            r_seen     <= '0;
            r_orderErr <= '0;
        end else if (w_clear) begin
            r_seen     <= '0;
            r_orderErr <= '0;
        end else begin
            for (int k = 0; k < NUM_DECODERS; k++) begin
                if (w_enable && w_data[k]) begin
                    if (w_bad[k]) begin
                        r_orderErr[k] <= 1'b1;
                    end else if (w_pop[k]) begin
                        r_seen[k]    <= 1'b1;
                        r_lastIdx[k] <= w_idx[k];
                    end
                end
            end
        end
    end

    assign order_err_o = r_orderErr;
`else
    assign w_bad = '0;
`endif

    always_comb begin
        w_pop   = '0;
        w_match = 1'b0;
        case (r_state)
            RUN: begin
                w_pop = w_data & w_bad;
                if (&w_good) begin
                    if (w_idx[0] == w_idx[1]) begin
                        w_match = 1'b1;
                        w_pop   = '1;
                    end else if (w_idx[0] < w_idx[1]) begin
                        w_pop[0] = 1'b1;
                    end else begin
                        w_pop[1] = 1'b1;
                    end
                end
            end
            FLUSH:   w_pop = w_data;
            default: w_pop = '0;
        endcase
    end

    // Terminators stay parked in their heads, which stalls that stream until the job restarts.
    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_state            <= IDLE;
            r_waitCnt          <= '0;
            comparator_valid_o <= 1'b0;
            comparator_done_o  <= 1'b0;
            comparator_data_o  <= '0;
        end else begin
            comparator_valid_o <= w_match;
            if (w_match) begin
                comparator_data_o <= w_val;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) r_state <= RUN;
                end
                RUN: begin
                    if (|w_term) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (&w_term) begin
                        r_state   <= WAIT;
                        r_waitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (comparator_valid_o) begin
                        r_waitCnt <= '0;
                    end else if ((DONE_LATENCY == 0) || (r_waitCnt == CNT_W'(DONE_LATENCY - 1))) begin
                        r_state           <= DONE;
                        comparator_done_o <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (start_i) begin
                        r_state           <= RUN;
                        comparator_done_o <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_index_comparator.sv
// Directed testbench for sparse_index_comparator; models the downstream MAC as a running sum.
module tb_sparse_index_comparator;
    import sparse_mac_pkg::*;

    localparam int NUM_DEC  = 2;
    localparam int DONE_LAT = 2;

    typedef struct packed {
        logic       last;
        index_bus_t idx;
        value_bus_t val;
    } token_t;

    logic                      mac_clk = 1'b0;
    logic                      mac_rst;
    logic                      start_i;
    logic       [NUM_DEC-1:0]  dec_valid_i;
    logic       [NUM_DEC-1:0]  dec_ready_o;
    logic       [NUM_DEC-1:0]  dec_last_i;
    index_bus_t [NUM_DEC-1:0]  dec_index_i;
    value_bus_t [NUM_DEC-1:0]  dec_value_i;
    logic                      comparator_valid_o;
    value_bus_t [NUM_DEC-1:0]  comparator_data_o;
    logic                      comparator_done_o;
`ifdef SPARSE_CMP_CHECK_EN
    logic       [NUM_DEC-1:0]  order_err_o;
`endif

    int total = 0;
    int bad   = 0;

    token_t               qA[$];
    token_t               qB[$];
    logic [2*VALUE_W-1:0] qExp[$];

    int nValid;
    int macSum;
    int xferA;
    int xferB;
    int firstValidCyc;
    int lastValidCyc;
    int doneCyc;

    always #5 mac_clk = ~mac_clk;

    sparse_index_comparator #(
        .NUM_DECODERS (NUM_DEC),
        .DONE_LATENCY (DONE_LAT)
    ) dut (
        .mac_clk            (mac_clk),
        .mac_rst            (mac_rst),
        .start_i            (start_i),
        .dec_valid_i        (dec_valid_i),
        .dec_ready_o        (dec_ready_o),
        .dec_last_i         (dec_last_i),
        .dec_index_i        (dec_index_i),
        .dec_value_i        (dec_value_i),
        .comparator_valid_o (comparator_valid_o),
        .comparator_data_o  (comparator_data_o),
        .comparator_done_o  (comparator_done_o)
`ifdef SPARSE_CMP_CHECK_EN
        ,
        .order_err_o        (order_err_o)
`endif
    );

    function automatic token_t dataTok(input int idx, input int val);
        token_t t;
        t.last = 1'b0;
        t.idx  = index_bus_t'(idx);
        t.val  = value_bus_t'(val);
        return t;
    endfunction

    function automatic token_t lastTok();
        token_t t;
        t      = '0;
        t.last = 1'b1;
        return t;
    endfunction

    function automatic logic [2*VALUE_W-1:0] pairOf(input int v1, input int v0);
        return {value_bus_t'(v1), value_bus_t'(v0)};
    endfunction

    task automatic clearQueues();
        qA.delete();
        qB.delete();
        qExp.delete();
    endtask

    task automatic idleInputs();
        dec_valid_i = '0;
        dec_last_i  = '0;
        dec_index_i = '0;
        dec_value_i = '0;
    endtask

    // Pulses start, streams qA/qB with optional random gaps, scores pairs against qExp.
    task automatic run_job(input int gapPct, input int maxCycles, input bit needDone);
        logic [NUM_DEC-1:0] xfer;
        nValid        = 0;
        macSum        = 0;
        xferA         = 0;
        xferB         = 0;
        firstValidCyc = -1;
        lastValidCyc  = -1;
        doneCyc       = -1;
        @(negedge mac_clk);
        start_i = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge mac_clk);
            start_i = 1'b0;
            if (c == 0) begin
                total++;
                if (comparator_done_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL done_after_start: got %b want 0", comparator_done_o);
                end
            end
            if (comparator_valid_o === 1'b1) begin
                total++;
                if (nValid >= qExp.size()) begin
                    bad++;
                    $display("[TB] FAIL extra_valid: got pair %h, expected no more pairs", comparator_data_o);
                end else if (comparator_data_o !== qExp[nValid]) begin
                    bad++;
                    $display("[TB] FAIL pair%0d: got %h want %h", nValid, comparator_data_o, qExp[nValid]);
                end
                if (firstValidCyc < 0) firstValidCyc = c;
                lastValidCyc = c;
                nValid++;
                macSum += int'(comparator_data_o[0]) * int'(comparator_data_o[1]);
            end
            if (comparator_done_o === 1'b1) begin
                doneCyc = c;
                break;
            end
            idleInputs();
            if (qA.size() > 0 && $urandom_range(99) >= gapPct) begin
                dec_valid_i[0] = 1'b1;
                dec_last_i[0]  = qA[0].last;
                dec_index_i[0] = qA[0].idx;
                dec_value_i[0] = qA[0].val;
            end
            if (qB.size() > 0 && $urandom_range(99) >= gapPct) begin
                dec_valid_i[1] = 1'b1;
                dec_last_i[1]  = qB[0].last;
                dec_index_i[1] = qB[0].idx;
                dec_value_i[1] = qB[0].val;
            end
            #1;
            xfer = dec_valid_i & dec_ready_o;
            @(posedge mac_clk);
            if (xfer[0]) begin
                void'(qA.pop_front());
                xferA++;
            end
            if (xfer[1]) begin
                void'(qB.pop_front());
                xferB++;
            end
        end
        idleInputs();
        if (needDone) begin
            total++;
            if (doneCyc < 0) begin
                bad++;
                $display("[TB] FAIL done_timeout: done not seen within %0d cycles", maxCycles);
            end
        end
    endtask

    task automatic test_reset();
        mac_rst = 1'b0;
        start_i = 1'b0;
        idleInputs();
        repeat (3) @(negedge mac_clk);
        total++;
        if (comparator_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_valid: got %b want 0", comparator_valid_o);
        end
        total++;
        if (comparator_done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_done: got %b want 0", comparator_done_o);
        end
        total++;
        if (dec_ready_o !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rst_ready: got %b want 00", dec_ready_o);
        end
        total++;
        if (comparator_data_o !== '0) begin
            bad++;
            $display("[TB] FAIL rst_data: got %h want 0", comparator_data_o);
        end
        mac_rst = 1'b1;
        dec_valid_i = 2'b11;
        repeat (2) @(negedge mac_clk);
        total++;
        if (dec_ready_o !== 2'b00) begin
            bad++;
            $display("[TB] FAIL idle_ready: got %b want 00", dec_ready_o);
        end
        idleInputs();
    endtask

    task automatic test_basic();
        clearQueues();
        qA = '{dataTok(1, 10), dataTok(3, 20), dataTok(5, 30), dataTok(7, 40), lastTok()};
        qB = '{dataTok(3, 2), dataTok(4, 9), dataTok(7, 5), dataTok(9, 1), lastTok()};
        qExp.push_back(pairOf(2, 20));
        qExp.push_back(pairOf(5, 40));
        run_job(0, 200, 1'b1);
        total++;
        if (nValid != 2) begin
            bad++;
            $display("[TB] FAIL basic_count: got %0d want 2", nValid);
        end
        total++;
        if (macSum != 240) begin
            bad++;
            $display("[TB] FAIL basic_sum: got %0d want 240", macSum);
        end
        total++;
        if (doneCyc - lastValidCyc - 1 < DONE_LAT) begin
            bad++;
            $display("[TB] FAIL basic_done_gap: got %0d idle cycles want >= %0d", doneCyc - lastValidCyc - 1, DONE_LAT);
        end
        total++;
        if (xferA != 5 || xferB != 5) begin
            bad++;
            $display("[TB] FAIL basic_xfers: got A=%0d B=%0d want 5/5", xferA, xferB);
        end
    endtask

    task automatic test_restart();
        repeat (3) @(negedge mac_clk);
        total++;
        if (comparator_done_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL done_held: got %b want 1", comparator_done_o);
        end
        clearQueues();
        qA = '{dataTok(2, 3), dataTok(6, 4), lastTok()};
        qB = '{dataTok(6, 11), lastTok()};
        qExp.push_back(pairOf(11, 4));
        run_job(0, 200, 1'b1);
        total++;
        if (nValid != 1 || macSum != 44) begin
            bad++;
            $display("[TB] FAIL restart_job: got count=%0d sum=%0d want 1/44", nValid, macSum);
        end
    endtask

    task automatic test_disjoint();
        clearQueues();
        qA = '{dataTok(0, 1), dataTok(2, 1), dataTok(4, 1), lastTok()};
        qB = '{dataTok(1, 1), dataTok(3, 1), dataTok(5, 1), lastTok()};
        run_job(0, 200, 1'b1);
        total++;
        if (nValid != 0) begin
            bad++;
            $display("[TB] FAIL disjoint_count: got %0d want 0", nValid);
        end
        total++;
        if (xferA + xferB != 8) begin
            bad++;
            $display("[TB] FAIL disjoint_xfers: got %0d want 8", xferA + xferB);
        end
    endtask

    task automatic test_early_term();
        clearQueues();
        qA.push_back(lastTok());
        for (int i = 1; i <= 100; i++) qB.push_back(dataTok(i, i));
        qB.push_back(lastTok());
        run_job(0, 400, 1'b1);
        total++;
        if (nValid != 0) begin
            bad++;
            $display("[TB] FAIL early_count: got %0d want 0", nValid);
        end
        total++;
        if (xferA != 1 || xferB != 101) begin
            bad++;
            $display("[TB] FAIL early_xfers: got A=%0d B=%0d want 1/101", xferA, xferB);
        end
    endtask

    task automatic test_gaps();
        clearQueues();
        for (int k = 0; k < 16; k++) begin
            qA.push_back(dataTok(k, k));
            qB.push_back(dataTok(k, k + 1));
            qExp.push_back(pairOf(k + 1, k));
        end
        qA.push_back(lastTok());
        qB.push_back(lastTok());
        run_job(35, 1000, 1'b1);
        total++;
        if (nValid != 16) begin
            bad++;
            $display("[TB] FAIL gaps_count: got %0d want 16", nValid);
        end
        total++;
        if (macSum != 1360) begin
            bad++;
            $display("[TB] FAIL gaps_sum: got %0d want 1360", macSum);
        end
    endtask

    task automatic test_back_to_back();
        clearQueues();
        for (int k = 0; k < 8; k++) begin
            qA.push_back(dataTok(k, k + 1));
            qB.push_back(dataTok(k, 2));
            qExp.push_back(pairOf(2, k + 1));
        end
        qA.push_back(lastTok());
        qB.push_back(lastTok());
        run_job(0, 200, 1'b1);
        total++;
        if (nValid != 8 || macSum != 72) begin
            bad++;
            $display("[TB] FAIL b2b_result: got count=%0d sum=%0d want 8/72", nValid, macSum);
        end
        total++;
        if (lastValidCyc - firstValidCyc != 7) begin
            bad++;
            $display("[TB] FAIL b2b_rate: got span %0d want 7", lastValidCyc - firstValidCyc);
        end
    endtask

    task automatic test_reset_mid_run();
        clearQueues();
        qA = '{dataTok(1, 10), dataTok(3, 20), dataTok(5, 30), dataTok(7, 40), lastTok()};
        qB = '{dataTok(3, 2), dataTok(4, 9), dataTok(7, 5), dataTok(9, 1), lastTok()};
        qExp.push_back(pairOf(2, 20));
        qExp.push_back(pairOf(5, 40));
        run_job(0, 5, 1'b0);
        total++;
        if (nValid != 1) begin
            bad++;
            $display("[TB] FAIL midrun_pairs: got %0d want 1", nValid);
        end
        #2;
        mac_rst = 1'b0;
        #1;
        total++;
        if (comparator_valid_o !== 1'b0 || comparator_done_o !== 1'b0 ||
            dec_ready_o !== 2'b00 || comparator_data_o !== '0) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got valid=%b done=%b ready=%b data=%h want 0/0/00/0",
                     comparator_valid_o, comparator_done_o, dec_ready_o, comparator_data_o);
        end
        repeat (2) @(negedge mac_clk);
        mac_rst = 1'b1;
        clearQueues();
    endtask

    task automatic test_empty();
        clearQueues();
        qA.push_back(lastTok());
        qB.push_back(lastTok());
        run_job(0, 100, 1'b1);
        total++;
        if (nValid != 0) begin
            bad++;
            $display("[TB] FAIL empty_count: got %0d want 0", nValid);
        end
    endtask

`ifdef SPARSE_CMP_CHECK_EN
    task automatic test_order();
        clearQueues();
        qA = '{dataTok(5, 50), dataTok(3, 30), dataTok(7, 70), lastTok()};
        qB = '{dataTok(3, 300), dataTok(7, 700), lastTok()};
        qExp.push_back(pairOf(700, 70));
        run_job(0, 200, 1'b1);
        total++;
        if (nValid != 1) begin
            bad++;
            $display("[TB] FAIL order_count: got %0d want 1", nValid);
        end
        total++;
        if (order_err_o !== 2'b01) begin
            bad++;
            $display("[TB] FAIL order_err: got %b want 01", order_err_o);
        end
        clearQueues();
        qA.push_back(lastTok());
        qB.push_back(lastTok());
        run_job(0, 100, 1'b1);
        total++;
        if (order_err_o !== 2'b00) begin
            bad++;
            $display("[TB] FAIL order_err_clear: got %b want 00", order_err_o);
        end
    endtask
`endif

    initial begin
        mac_rst = 1'b0;
        start_i = 1'b0;
        idleInputs();
        test_reset();
        test_basic();
        test_restart();
        test_disjoint();
        test_early_term();
        test_gaps();
        test_back_to_back();
        test_reset_mid_run();
        test_empty();
`ifdef SPARSE_CMP_CHECK_EN
        test_order();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
